// File: rtl/marcador_puntaje_pkg.sv
// Shared types and constants for the score/lives tracker and the game FSM.
package marcador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JUGANDO = 2'd1,
    INVULN  = 2'd2,
    FIN     = 2'd3
  } estado_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [3:0]  EST_JUEGO = 4'd3;

endpackage

// File: rtl/marcador_puntaje_if.sv
// Bundle between the game side (presente, obstacle/collision levels) and the tracker outputs.
interface marcador_puntaje_if;
  import marcador_pkg::*;

  // No valid/ready here: tick_obs, choque and bono are free-running levels from
  // the clk_ob domain; the tracker synchronises them and acts on each rising edge.
  logic [3:0]  presente;
  logic        tick_obs;
  logic        choque;
  logic        bono;
  logic [15:0] puntos;
  logic [1:0]  vidas;
  logic        invuln;
  logic        game_over;
  estado_t     estado;

  modport master (
    output presente, tick_obs, choque, bono,
    input  puntos, vidas, invuln, game_over, estado
  );

  modport slave (
    input  presente, tick_obs, choque, bono,
    output puntos, vidas, invuln, game_over, estado
  );

endinterface

// File: rtl/marcador_puntaje_sumador.sv
// 4-digit BCD value plus a small binary addend (0..10), saturating at 9999.
module bcd_sumador_sat
  import marcador_pkg::*;
(
  input  logic [15:0] a,
  input  logic [4:0]  b,
  output logic [15:0] suma
);

  logic [3:0]  uni;
  logic [3:0]  dec;
  logic [3:0]  dig_add;
  logic [4:0]  t;
  logic        c;
  logic [15:0] res;

  always_comb begin
    uni     = (b >= 5'd10) ? 4'(b - 5'd10) : b[3:0];
    dec     = (b >= 5'd10) ? 4'd1 : 4'd0;
    c       = 1'b0;
    t       = '0;
    dig_add = '0;
    res     = '0;
    for (int i = 0; i < 4; i++) begin
      dig_add = (i == 0) ? uni : ((i == 1) ? dec : 4'd0);
      t = {1'b0, a[4*i +: 4]} + {1'b0, dig_add} + {4'd0, c};
      if (t > 5'd9) begin
        t = t - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      res[4*i +: 4] = t[3:0];
    end
    // A carry out of the thousands digit means the score passed 9999.
    suma = c ? BCD_MAX : res;
  end

endmodule

// File: rtl/marcador_puntaje.sv
// Score and lives tracker: synchronises obstacle/collision/bonus levels, scores in BCD, flags game over.
module marcador_puntaje #(
  parameter int          VIDAS_INI    = 3,
  parameter int          PUNTOS_BONO  = 5,
  parameter int          INVULN_TICKS = 4,
  parameter logic [3:0]  EST_JUEGO    = marcador_pkg::EST_JUEGO
) (
  input  logic               clk,
  input  logic               rst,
  marcador_puntaje_if.slave  bus
);
  import marcador_pkg::*;

  // [0],[1]: two-flop synchroniser; [2]: previous synchronised level for edge detection.
  logic [2:0]  s_tick, s_choque, s_bono;
  logic        e_tick, e_choque, e_bono;
  logic        juego;
  logic [4:0]  addend;
  logic [15:0] suma;

  estado_t     estado;
  logic [15:0] puntos;
  logic [1:0]  vidas;
  logic        invuln;
  logic        game_over;
  logic [3:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_tick   <= '0;
      s_choque <= '0;
      s_bono   <= '0;
    end else begin
      s_tick   <= {s_tick[1:0],   bus.tick_obs};
      s_choque <= {s_choque[1:0], bus.choque};
      s_bono   <= {s_bono[1:0],   bus.bono};
    end
  end

  assign e_tick   = s_tick[1]   & ~s_tick[2];
  assign e_choque = s_choque[1] & ~s_choque[2];
  assign e_bono   = s_bono[1]   & ~s_bono[2];
  assign juego    = (bus.presente == EST_JUEGO);
  assign addend   = (e_tick ? 5'd1 : 5'd0) + (e_bono ? 5'(PUNTOS_BONO) : 5'd0);

  bcd_sumador_sat u_sumador (
    .a    (puntos),
    .b    (addend),
    .suma (suma)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= IDLE;
      puntos    <= 16'h0000;
      vidas     <= 2'd0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      game_over <= 1'b0;
      case (estado)
        IDLE: begin
          if (juego) begin
            puntos <= 16'h0000;
            vidas  <= 2'(VIDAS_INI);
            estado <= JUGANDO;
          end
        end
        JUGANDO: begin
          if (!juego) begin
            estado <= IDLE;
          end else begin
            puntos <= suma;
            if (e_choque) begin
              if (vidas > 2'd1) begin
                vidas  <= vidas - 2'd1;
                cnt    <= 4'(INVULN_TICKS);
                invuln <= 1'b1;
                estado <= INVULN;
              end else begin
                vidas     <= 2'd0;
                game_over <= 1'b1;
                estado    <= FIN;
              end
            end
          end
        end
        INVULN: begin
          if (!juego) begin
            invuln <= 1'b0;
            estado <= IDLE;
          end else begin
            puntos <= suma;
            if (e_tick) begin
              if (cnt == 4'd1) begin
                cnt    <= 4'd0;
                invuln <= 1'b0;
                estado <= JUGANDO;
              end else begin
                cnt <= cnt - 4'd1;
              end
            end
          end
        end
        FIN: begin
          if (!juego) estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.puntos    = puntos;
  assign bus.vidas     = vidas;
  assign bus.invuln    = invuln;
  assign bus.game_over = game_over;
  assign bus.estado    = estado;

endmodule
